// File: rtl/conv_cfg_pkg.sv
// rtl/conv_cfg_pkg.sv - shared constants, selector encodings and helpers for the configurable convolver
package conv_cfg_pkg;

    typedef enum logic [2:0] {
        KSEL_IDENTITY = 3'd0,
        KSEL_BORDER   = 3'd1,
        KSEL_GAUSSIAN = 3'd2,
        KSEL_SHARPEN  = 3'd3,
        KSEL_USER     = 3'd4
    } kernel_sel_e;

    localparam int NB_SHIFT = 5;

    // Presets are defined for the 3x3 window, row-major
    localparam int PRESET_IDENTITY [9] = '{ 0,  0,  0,  0, 1,  0,  0,  0,  0};
    localparam int PRESET_BORDER   [9] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    localparam int PRESET_GAUSSIAN [9] = '{ 1,  2,  1,  2, 4,  2,  1,  2,  1};
    localparam int PRESET_SHARPEN  [9] = '{ 0, -1,  0, -1, 5, -1,  0, -1,  0};
    localparam int SHIFT_GAUSSIAN      = 4;

    function automatic int calc_nb_acc(input int nb_pixel, input int nb_coeff, input int kernel_size);
        return nb_pixel + nb_coeff + 1 + $clog2(kernel_size);
    endfunction

    // The shift field sits just past the last tap in the coefficient address map
    function automatic int shift_field_addr(input int kernel_size);
        return kernel_size;
    endfunction

    function automatic int preset_coef(input logic [2:0] sel, input int tap);
        case (sel)
            KSEL_BORDER:   return PRESET_BORDER[tap];
            KSEL_GAUSSIAN: return PRESET_GAUSSIAN[tap];
            KSEL_SHARPEN:  return PRESET_SHARPEN[tap];
            default:       return PRESET_IDENTITY[tap];
        endcase
    endfunction

    function automatic int preset_shift(input logic [2:0] sel);
        return (sel == KSEL_GAUSSIAN) ? SHIFT_GAUSSIAN : 0;
    endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// rtl/conv_lane_mac.sv - one lane: tap products, adder tree, arithmetic shift and unsigned clamp
module conv_lane_mac
    import conv_cfg_pkg::*;
#(
    parameter int KERNEL_SIZE = 9,
    parameter int NB_PIXEL    = 8,
    parameter int NB_COEFF    = 8,
    parameter int NB_ACC      = 21
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [KERNEL_SIZE*NB_PIXEL-1:0] window,
    input  logic [KERNEL_SIZE*NB_COEFF-1:0] coefs,
    input  logic [NB_SHIFT-1:0]             shift,
    input  logic                            load,
    output logic [NB_PIXEL-1:0]             result,
    output logic                            sat
);

    localparam int NB_PROD = NB_PIXEL + NB_COEFF + 1;
    localparam logic signed [NB_ACC-1:0] PIX_MAX = NB_ACC'((1 << NB_PIXEL) - 1);

    logic signed [NB_PROD-1:0] prod_d [KERNEL_SIZE];
    logic signed [NB_PROD-1:0] prod_q [KERNEL_SIZE];
    logic signed [NB_ACC-1:0]  acc_d;
    logic signed [NB_ACC-1:0]  acc_q;
    logic signed [NB_ACC-1:0]  shifted;
    logic [NB_SHIFT-1:0]       shift1_q;
    logic [NB_SHIFT-1:0]       shift2_q;
    logic                      neg;

    always_comb begin
        acc_d = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            // Pixels are unsigned, so a zero sign bit is prepended before the signed multiply
            prod_d[k] = NB_PROD'($signed({1'b0, window[k*NB_PIXEL +: NB_PIXEL]}))
                      * NB_PROD'($signed(coefs[k*NB_COEFF +: NB_COEFF]));
            acc_d = acc_d + NB_ACC'(prod_q[k]);
        end
        shifted = acc_q >>> shift2_q;
        neg     = shifted[NB_ACC-1];
        sat     = neg || (shifted > PIX_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < KERNEL_SIZE; k++) prod_q[k] <= '0;
            acc_q    <= '0;
            shift1_q <= '0;
            shift2_q <= '0;
            result   <= '0;
        end else begin
            prod_q   <= prod_d;
            shift1_q <= shift;
            acc_q    <= acc_d;
            shift2_q <= shift1_q;
            if (load) result <= sat ? (neg ? '0 : '1) : shifted[NB_PIXEL-1:0];
        end
    end

endmodule

// File: rtl/conv_engine_cfg.sv
// rtl/conv_engine_cfg.sv - N-lane 3x3 convolver with frame-latched kernel select and shadow/active user bank
module conv_engine_cfg
    import conv_cfg_pkg::*;
#(
    parameter int KERNEL_WIDTH = 3,
    parameter int KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH,
    parameter int NB_PIXEL     = 8,
    parameter int NB_COEFF     = 8,
    parameter int NB_DATA      = 32,
    parameter int N_LANES      = NB_DATA / NB_PIXEL,
    parameter int NB_ADDR      = 4,
    parameter int NB_ACC       = calc_nb_acc(NB_PIXEL, NB_COEFF, KERNEL_SIZE),
    parameter int NB_SATCNT    = 16
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic [N_LANES*KERNEL_SIZE*NB_PIXEL-1:0] i_window,
    input  logic                                    i_valid,
    input  logic                                    i_sof,
    input  logic [2:0]                              i_kernel_sel,
    input  logic                                    i_coef_we,
    input  logic [NB_ADDR-1:0]                      i_coef_addr,
    input  logic [NB_COEFF-1:0]                     i_coef_data,
    input  logic                                    i_coef_commit,
    output logic [NB_DATA-1:0]                      o_data,
    output logic                                    o_valid,
    output logic                                    o_cfg_pending,
    output logic [NB_SATCNT-1:0]                    o_sat_count
);

    localparam int CENTER     = KERNEL_SIZE / 2;
    localparam int SHIFT_ADDR = shift_field_addr(KERNEL_SIZE);
    localparam int NB_LANECNT = $clog2(N_LANES + 1);

    logic [NB_COEFF-1:0]             shadow_coef [KERNEL_SIZE];
    logic [NB_COEFF-1:0]             active_coef [KERNEL_SIZE];
    logic [NB_SHIFT-1:0]             shadow_shift;
    logic [NB_SHIFT-1:0]             active_shift;
    logic [2:0]                      sel_q;
    logic                            pending_q;
    logic                            v1_q;
    logic                            v2_q;
    logic                            sof_beat;
    logic                            use_shadow;
    logic [2:0]                      sel_eff;
    logic [KERNEL_SIZE*NB_COEFF-1:0] coefs;
    logic [NB_SHIFT-1:0]             shift;
    logic [N_LANES-1:0]              sat;
    logic [NB_LANECNT-1:0]           n_sat;
    logic [NB_SATCNT:0]              sat_sum;

    // A sof beat already sees its own selection and, if a commit is pending, the shadow bank
    always_comb begin
        sof_beat   = i_valid && i_sof;
        sel_eff    = sof_beat ? i_kernel_sel : sel_q;
        use_shadow = sof_beat && pending_q;
        coefs      = '0;
        shift      = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            if (sel_eff == KSEL_USER)
                coefs[k*NB_COEFF +: NB_COEFF] = use_shadow ? shadow_coef[k] : active_coef[k];
            else
                coefs[k*NB_COEFF +: NB_COEFF] = NB_COEFF'(preset_coef(sel_eff, k));
        end
        if (sel_eff == KSEL_USER)
            shift = use_shadow ? shadow_shift : active_shift;
        else
            shift = NB_SHIFT'(preset_shift(sel_eff));
        n_sat = '0;
        for (int l = 0; l < N_LANES; l++) n_sat = n_sat + NB_LANECNT'(sat[l]);
        sat_sum = {1'b0, o_sat_count} + (NB_SATCNT+1)'(n_sat);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                shadow_coef[k] <= (k == CENTER) ? NB_COEFF'(1) : '0;
                active_coef[k] <= (k == CENTER) ? NB_COEFF'(1) : '0;
            end
            shadow_shift <= '0;
            active_shift <= '0;
            sel_q        <= '0;
            pending_q    <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            o_valid      <= 1'b0;
            o_sat_count  <= '0;
        end else begin
            if (i_coef_we) begin
                if (i_coef_addr < NB_ADDR'(KERNEL_SIZE))
                    shadow_coef[i_coef_addr] <= i_coef_data;
                else if (i_coef_addr == NB_ADDR'(SHIFT_ADDR))
                    shadow_shift <= i_coef_data[NB_SHIFT-1:0];
            end
            if (sof_beat) sel_q <= i_kernel_sel;
            // A commit landing on the applying sof re-arms for the following sof
            if (use_shadow) begin
                active_coef  <= shadow_coef;
                active_shift <= shadow_shift;
                pending_q    <= i_coef_commit;
            end else if (i_coef_commit) begin
                pending_q <= 1'b1;
            end
            v1_q    <= i_valid;
            v2_q    <= v1_q;
            o_valid <= v2_q;
            if (v2_q) o_sat_count <= sat_sum[NB_SATCNT] ? '1 : sat_sum[NB_SATCNT-1:0];
        end
    end

    assign o_cfg_pending = pending_q;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        conv_lane_mac #(
            .KERNEL_SIZE (KERNEL_SIZE),
            .NB_PIXEL    (NB_PIXEL),
            .NB_COEFF    (NB_COEFF),
            .NB_ACC      (NB_ACC)
        ) u_mac (
            .clk    (i_clk),
            .reset  (i_reset),
            .window (i_window[l*KERNEL_SIZE*NB_PIXEL +: KERNEL_SIZE*NB_PIXEL]),
            .coefs  (coefs),
            .shift  (shift),
            .load   (v2_q),
            .result (o_data[l*NB_PIXEL +: NB_PIXEL]),
            .sat    (sat[l])
        );
    end

endmodule

// File: tb/tb_conv_engine_cfg.sv
// tb/tb_conv_engine_cfg.sv - directed bench for conv_engine_cfg with immediate assertions
module tb_conv_engine_cfg;

    localparam int KS = 9;
    localparam int NL = 4;
    localparam int NW = NL * KS * 8;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic [NW-1:0] i_window;
    logic          i_valid;
    logic          i_sof;
    logic [2:0]    i_kernel_sel;
    logic          i_coef_we;
    logic [3:0]    i_coef_addr;
    logic [7:0]    i_coef_data;
    logic          i_coef_commit;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          o_cfg_pending;
    logic [15:0]   o_sat_count;

    int n_assert = 0;
    int n_fail   = 0;

    conv_engine_cfg dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_window      (i_window),
        .i_valid       (i_valid),
        .i_sof         (i_sof),
        .i_kernel_sel  (i_kernel_sel),
        .i_coef_we     (i_coef_we),
        .i_coef_addr   (i_coef_addr),
        .i_coef_data   (i_coef_data),
        .i_coef_commit (i_coef_commit),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_cfg_pending (o_cfg_pending),
        .o_sat_count   (o_sat_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [NW-1:0] win(input logic [7:0] c0, input logic [7:0] c1,
                                          input logic [7:0] c2, input logic [7:0] c3,
                                          input logic [7:0] nb);
        logic [NW-1:0] w;
        logic [7:0]    c [NL];
        c = '{c0, c1, c2, c3};
        for (int l = 0; l < NL; l++)
            for (int k = 0; k < KS; k++)
                w[(l*KS+k)*8 +: 8] = (k == 4) ? c[l] : nb;
        return w;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic beat(input logic sof, input logic [2:0] sel, input logic [NW-1:0] w);
        i_valid      = 1'b1;
        i_sof        = sof;
        i_kernel_sel = sel;
        i_window     = w;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        i_coef_we   = 1'b1;
        i_coef_addr = addr;
        i_coef_data = data;
        step();
        i_coef_we   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_reset = 1'b1; i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0;
        i_coef_commit = 1'b0; idle(); i_kernel_sel = '0; i_window = '0;

        for (int i = 0; i < 5; i++) begin
            i_window      = {9{$urandom()}};
            i_valid       = 1'($urandom());
            i_sof         = 1'($urandom());
            i_kernel_sel  = 3'($urandom_range(7, 0));
            i_coef_we     = 1'($urandom());
            i_coef_addr   = 4'($urandom_range(15, 0));
            i_coef_data   = 8'($urandom());
            i_coef_commit = 1'($urandom());
            step();
        end
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_sat", o_sat_count, 0);
        check("rst_pending", o_cfg_pending, 0);
        i_reset = 1'b0; i_coef_we = 1'b0; i_coef_commit = 1'b0; idle();
        repeat (4) step();
        check("idle_valid", o_valid, 0);
        check("idle_data", o_data, 0);

        // identity
        beat(1, 0, win(10, 20, 30, 200, 99)); step();
        beat(0, 0, win(1, 2, 3, 4, 99));      step();
        idle(); step();
        check("id_valid0", o_valid, 1);
        check("id_data0", o_data, 32'hC81E140A);
        step();
        check("id_valid1", o_valid, 1);
        check("id_data1", o_data, 32'h04030201);
        step();
        check("id_valid_drop", o_valid, 0);
        check("id_hold", o_data, 32'h04030201);

        // border with clamping
        beat(1, 1, win(100, 100, 100, 100, 100)); step();
        beat(0, 1, win(255, 255, 255, 255, 0));   step();
        beat(0, 1, win(0, 0, 0, 0, 255));         step();
        idle();
        check("bd_flat", o_data, 32'h00000000);
        check("bd_sat0", o_sat_count, 0);
        step();
        check("bd_high", o_data, 32'hFFFFFFFF);
        check("bd_sat4", o_sat_count, 4);
        step();
        check("bd_low", o_data, 32'h00000000);
        check("bd_sat8", o_sat_count, 8);
        step();

        // gaussian, mid-frame select change ignored
        beat(1, 2, win(160, 160, 160, 160, 160)); step();
        beat(0, 0, win(160, 160, 160, 160, 0));   step();
        idle(); step();
        check("ga_flat", o_data, 32'hA0A0A0A0);
        step();
        check("ga_midsel_valid", o_valid, 1);
        check("ga_midsel", o_data, 32'h28282828);

        // user bank: all ones, shift 3, out-of-range write ignored
        for (int k = 0; k < KS; k++) wr(4'(k), 8'd1);
        wr(4'd9, 8'd3);
        wr(4'd10, 8'd0);
        i_coef_commit = 1'b1; step(); i_coef_commit = 1'b0;
        check("ub_pending_set", o_cfg_pending, 1);
        beat(0, 4, win(160, 160, 160, 160, 160)); step();
        check("ub_pending_hold", o_cfg_pending, 1);
        beat(1, 4, win(8, 8, 8, 8, 8)); step();
        check("ub_pending_clr", o_cfg_pending, 0);
        idle(); step();
        check("ub_nonsof", o_data, 32'hA0A0A0A0);
        step();
        check("ub_applied", o_data, 32'h09090909);

        // commit on a sof beat is deferred
        wr(4'd9, 8'd0);
        i_coef_commit = 1'b1; beat(1, 4, win(8, 8, 8, 8, 8)); step();
        i_coef_commit = 1'b0;
        check("cs_pending", o_cfg_pending, 1);
        beat(1, 4, win(8, 8, 8, 8, 8)); step();
        check("cs_pending_clr", o_cfg_pending, 0);
        idle(); step();
        check("cs_old_bank", o_data, 32'h09090909);
        step();
        check("cs_new_bank", o_data, 32'h48484848);
        check("cs_sat", o_sat_count, 8);

        // reset with beats in flight
        i_coef_commit = 1'b1; step(); i_coef_commit = 1'b0;
        beat(0, 4, win(8, 8, 8, 8, 8)); step();
        beat(0, 4, win(8, 8, 8, 8, 8)); step();
        idle(); i_reset = 1'b1; step(); i_reset = 1'b0;
        check("mr_valid", o_valid, 0);
        check("mr_pending", o_cfg_pending, 0);
        check("mr_sat", o_sat_count, 0);
        step();
        check("mr_drop", o_valid, 0);
        beat(0, 2, win(77, 77, 77, 77, 5)); step();
        beat(1, 4, win(33, 33, 33, 33, 5)); step();
        idle(); step();
        check("mr_identity", o_data, 32'h4D4D4D4D);
        step();
        check("mr_user_reset", o_data, 32'h21212121);

        // saturation counter sticks at all-ones
        beat(1, 1, win(255, 255, 255, 255, 0)); step();
        i_sof = 1'b0;
        repeat (16399) step();
        idle(); repeat (3) step();
        check("sat_sticky", o_sat_count, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
